// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin arbiter sharing one registered 32-bit adder
//
// Purpose:
//   Time-multiplexes a single 32-bit adder between NREQ requesters (e.g. PC+4,
//   branch target and address calculation). One requester is granted per cycle
//   in round-robin order. Its operands are added and the result is registered.
//   The result is then presented with the owner's ID on a valid/ready response port.
//
// Parameters:
//   NREQ - number of requesters, 2..8 (need not be a power of two)
//   IDW  - requester ID width, 2**IDW >= NREQ
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   req_valid  in   [NREQ]     requester i has operands pending
//   req_a      in   [NREQ*32]  operand A, requester i at [32*i +: 32]
//   req_b      in   [NREQ*32]  operand B, same packing
//   req_ready  out  [NREQ]     one-hot grant (accept = valid & ready)
//   rsp_valid  out             registered result available
//   rsp_id     out  [IDW]      requester that owns the result
//   rsp_sum    out  [32]       a + b modulo 2**32
//   rsp_carry  out             unsigned carry-out of bit 31
//   rsp_ovf    out             signed overflow (only with ADD_ARB_OVF_EN)
//   rsp_ready  in              consumer accepts the result
//
// Build option:
//   ADD_ARB_OVF_EN - when defined, adds the registered rsp_ovf output.

module add_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*32-1:0]  req_a,
   input  logic [NREQ*32-1:0]  req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic                rsp_valid,
   output logic [IDW-1:0]      rsp_id,
   output logic [31:0]         rsp_sum,
   output logic                rsp_carry,
`ifdef ADD_ARB_OVF_EN
   output logic                rsp_ovf,
`endif
   input  logic                rsp_ready
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_sum_q, rsp_sum_d;
   logic            rsp_carry_q, rsp_carry_d;
`ifdef ADD_ARB_OVF_EN
   logic            rsp_ovf_q, rsp_ovf_d;
`endif

   logic            can_accept;
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic            grant_valid;
   logic [IDW-1:0]  rr_next;
   logic [31:0]     a_sel;
   logic [31:0]     b_sel;
   logic [32:0]     sum_full;

   // A new result may be accepted when nothing is held, or when the held
   // result leaves this cycle.
   assign can_accept = (state_q == IDLE) | rsp_ready;

   // Round-robin search in two passes. The first pass covers rr_ptr..NREQ-1.
   // The second pass wraps to 0..rr_ptr-1. This avoids modulo arithmetic on
   // non-power-of-two NREQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!grant_found && req_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(i);
         end
      end
   end

   // Reset gating keeps req_ready low while reset is asserted, even before
   // the state registers have been initialised.
   assign grant_valid = grant_found & can_accept & ~reset;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = grant_valid && (grant_idx == IDW'(i));
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == IDW'(i)) begin
            a_sel = req_a[32*i +: 32];
            b_sel = req_b[32*i +: 32];
         end
      end
   end

   // The single shared adder. Bit 32 is the unsigned carry-out.
   assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

   // The pointer moves past the winner so that the winner has lowest priority next.
   assign rr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A grant in HOLD implies rsp_ready, so the old result leaves
            // and the new one takes its place in the same cycle.
            if (grant_valid) begin
               state_d = HOLD;
            end else if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------
   always_comb begin
      rsp_valid = (state_q == HOLD);
   end

   // ---------------------------------------------------------------------
   // Datapath registers. They load only on a grant. Otherwise they keep
   // the last result, even after it has been consumed.
   // ---------------------------------------------------------------------
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_carry_d = rsp_carry_q;
`ifdef ADD_ARB_OVF_EN
      rsp_ovf_d   = rsp_ovf_q;
`endif
      if (grant_valid) begin
         rr_ptr_d    = rr_next;
         rsp_id_d    = grant_idx;
         rsp_sum_d   = sum_full[31:0];
         rsp_carry_d = sum_full[32];
`ifdef ADD_ARB_OVF_EN
         // Signed overflow: both operands have the same sign and the sum has a different sign.
         rsp_ovf_d   = (a_sel[31] == b_sel[31]) && (sum_full[31] != a_sel[31]);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_carry_q <= 1'b0;
`ifdef ADD_ARB_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_carry_q <= rsp_carry_d;
`ifdef ADD_ARB_OVF_EN
         rsp_ovf_q   <= rsp_ovf_d;
`endif
      end
   end

   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_carry = rsp_carry_q;
`ifdef ADD_ARB_OVF_EN
   assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - self-checking bench for add_arbiter

module tb_add_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*32-1:0]  req_a;
   logic [NREQ*32-1:0]  req_b;
   logic [NREQ-1:0]     req_ready;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [31:0]         rsp_sum;
   logic                rsp_carry;
`ifdef ADD_ARB_OVF_EN
   logic                rsp_ovf;
`endif
   logic                rsp_ready;

   int errors = 0;
   int checks = 0;

   logic [31:0] a_arr [NREQ];
   logic [31:0] b_arr [NREQ];

   // Reference model state
   int          m_ptr;
   bit          m_hold;
   int          m_id;
   logic [31:0] m_sum;
   bit          m_carry;
`ifdef ADD_ARB_OVF_EN
   bit          m_ovf;
`endif
   int          m_grant;

   always #5 clk = ~clk;

   add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
`ifdef ADD_ARB_OVF_EN
      .rsp_ovf   (rsp_ovf),
`endif
      .rsp_ready (rsp_ready)
   );

   // First valid requester in the order ptr, ptr+1, ..., wrapping modulo NREQ.
   function automatic int ref_grant(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (ptr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] r;
      r = '0;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      if (reset) return '0;
      if (m_hold && !rsp_ready) return '0;
      return onehot(ref_grant(req_valid, m_ptr));
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 4))
         0: return 32'hFFFF_FFFF;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         req_a[32*i +: 32] = a_arr[i];
         req_b[32*i +: 32] = b_arr[i];
      end
   endtask

   // Advance the model with the inputs as they stand at the coming edge.
   task automatic model_update();
      logic [32:0] t;
      m_grant = -1;
      if (reset) begin
         m_ptr = 0; m_hold = 0; m_id = 0; m_sum = '0; m_carry = 0;
`ifdef ADD_ARB_OVF_EN
         m_ovf = 0;
`endif
      end else begin
         if (!m_hold || rsp_ready) m_grant = ref_grant(req_valid, m_ptr);
         if (m_grant >= 0) begin
            t       = {1'b0, a_arr[m_grant]} + {1'b0, b_arr[m_grant]};
            m_sum   = t[31:0];
            m_carry = t[32];
`ifdef ADD_ARB_OVF_EN
            m_ovf   = (a_arr[m_grant][31] == b_arr[m_grant][31]) && (t[31] != a_arr[m_grant][31]);
`endif
            m_id    = m_grant;
            m_hold  = 1;
            m_ptr   = (m_grant + 1) % NREQ;
         end else if (m_hold && rsp_ready) begin
            m_hold = 0;
         end
      end
   endtask

   task automatic tick();
      apply();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      rsp_ready = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      apply();
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (req_ready !== '0) begin
            errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
         end
         checks++;
         if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== '0 || rsp_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: got v=%b id=%0d sum=%h c=%b want all 0", rsp_valid, rsp_id, rsp_sum, rsp_carry);
         end
      end
      reset = 1'b0;
      #2;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== a_arr[0] + b_arr[0]) begin
         errors++;
         $display("FAIL reset_first_rsp: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", rsp_valid, rsp_id, rsp_sum, a_arr[0] + b_arr[0]);
      end
   endtask

   task automatic test_single();
      drain();
      req_valid = 4'b0100;
      a_arr[2]  = 32'h0000_0004;
      b_arr[2]  = 32'h0040_0000;
      rsp_ready = 1'b1;
      apply();
      #2;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 32'h0040_0004 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: got v=%b id=%0d sum=%h c=%b want v=1 id=2 sum=00400004 c=0", rsp_valid, rsp_id, rsp_sum, rsp_carry);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = $urandom;
         b_arr[i] = $urandom;
      end
      apply();
      for (int k = 0; k < 5; k++) begin
         #2;
         checks++;
         if (req_ready !== onehot(k % NREQ)) begin
            errors++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, onehot(k % NREQ));
         end
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== IDW'(k % NREQ) || rsp_sum !== a_arr[k % NREQ] + b_arr[k % NREQ]) begin
            errors++;
            $display("FAIL rr_rsp%0d: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", k, rsp_valid, rsp_id, rsp_sum, k % NREQ, a_arr[k % NREQ] + b_arr[k % NREQ]);
         end
      end
   endtask

   // Runs right after test_round_robin: requester 0 result held, pointer at 1.
   task automatic test_backpressure();
      logic [31:0] held_sum;
      held_sum  = a_arr[0] + b_arr[0];
      rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (req_ready !== '0) begin
            errors++; $display("FAIL bp_ready%0d: got %b want 0", c, req_ready);
         end
         tick();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== held_sum) begin
            errors++;
            $display("FAIL bp_stable%0d: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", c, rsp_valid, rsp_id, rsp_sum, held_sum);
         end
      end
      rsp_ready = 1'b1;
      #2;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL bp_release: got %b want 0010", req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
         errors++; $display("FAIL bp_next: got v=%b id=%0d want v=1 id=1", rsp_valid, rsp_id);
      end
   endtask

   task automatic test_wrap_carry();
      drain();
      req_valid = 4'b0010;
      a_arr[1]  = 32'hFFFF_FFFF;
      b_arr[1]  = 32'h0000_0001;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0 || rsp_carry !== 1'b1) begin
         errors++; $display("FAIL wrap_carry: got v=%b sum=%h c=%b want v=1 sum=0 c=1", rsp_valid, rsp_sum, rsp_carry);
      end
`ifdef ADD_ARB_OVF_EN
      checks++;
      if (rsp_ovf !== 1'b0) begin
         errors++; $display("FAIL wrap_ovf: got %b want 0", rsp_ovf);
      end
`endif
      a_arr[1] = 32'h7FFF_FFFF;
      b_arr[1] = 32'h0000_0001;
      tick();
      req_valid = '0;
      checks++;
      if (rsp_sum !== 32'h8000_0000 || rsp_carry !== 1'b0) begin
         errors++; $display("FAIL signed_wrap: got sum=%h c=%b want sum=80000000 c=0", rsp_sum, rsp_carry);
      end
`ifdef ADD_ARB_OVF_EN
      checks++;
      if (rsp_ovf !== 1'b1) begin
         errors++; $display("FAIL signed_ovf: got %b want 1", rsp_ovf);
      end
`endif
   endtask

   task automatic test_reset_mid_hold();
      drain();
      req_valid = 4'b0100;
      tick();
      req_valid = '1;
      rsp_ready = 1'b0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL midhold_held: got v=%b want 1", rsp_valid);
      end
      reset = 1'b1;
      #2;
      checks++;
      if (req_ready !== '0) begin
         errors++; $display("FAIL midhold_ready_in_reset: got %b want 0", req_ready);
      end
      tick();
      reset = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL midhold_discard: got v=%b want 0", rsp_valid);
      end
      #2;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL midhold_ptr0: got %b want 0001", req_ready);
      end
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
         errors++; $display("FAIL midhold_next: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id);
      end
   endtask

   task automatic test_random();
      int waits [NREQ];
      logic [NREQ-1:0] exp;
      do_reset();
      req_valid = '0;
      for (int i = 0; i < NREQ; i++) waits[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i] = 1'b1;
               a_arr[i]     = rand_op();
               b_arr[i]     = rand_op();
               waits[i]     = 0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         apply();
         #2;
         exp = exp_ready();
         checks++;
         if (req_ready !== exp) begin
            errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp);
         end
         tick();
         if (m_grant >= 0) begin
            for (int i = 0; i < NREQ; i++) begin
               if (req_valid[i] && i != m_grant) begin
                  waits[i]++;
                  checks++;
                  if (waits[i] >= NREQ) begin
                     errors++; $display("FAIL rand_starve c%0d: req %0d waited %0d grants, limit %0d", c, i, waits[i], NREQ - 1);
                  end
               end
            end
            req_valid[m_grant] = 1'b0;
         end
         checks++;
         if (rsp_valid !== m_hold || rsp_id !== IDW'(m_id) || rsp_sum !== m_sum || rsp_carry !== m_carry) begin
            errors++;
            $display("FAIL rand_rsp c%0d: got v=%b id=%0d sum=%h c=%b want v=%b id=%0d sum=%h c=%b",
                     c, rsp_valid, rsp_id, rsp_sum, rsp_carry, m_hold, m_id, m_sum, m_carry);
         end
`ifdef ADD_ARB_OVF_EN
         checks++;
         if (rsp_ovf !== m_ovf) begin
            errors++; $display("FAIL rand_ovf c%0d: got %b want %b", c, rsp_ovf, m_ovf);
         end
`endif
      end
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = '0;
         b_arr[i] = '0;
      end
      apply();
      m_ptr = 0; m_hold = 0; m_id = 0; m_sum = '0; m_carry = 0; m_grant = -1;
`ifdef ADD_ARB_OVF_EN
      m_ovf = 0;
`endif
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap_carry();
      test_reset_mid_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
